// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan controller.
//   SEG_TABLE : active-high g..a patterns for hex digits 0..F (entry n = digit n)
//   SEG_DP    : bit position of the decimal point on the segment bus
//   clog2     : ceiling log2, never less than 1 (counters always keep one bit)
package sevenseg_pkg;

   localparam int unsigned SEG_DP = 7;

   // Listed F down to 0 so that SEG_TABLE[n] selects digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Data/control bundle between a display data source and the scan controller.
//   digits_in/dp_in/blank_in/load/brightness : source -> controller
//   seg_out/anode/digit_idx/frame_tick       : controller -> pins / source
interface sevenseg_scan_ctrl_if
   import sevenseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BRIGHT_W   = 4
);
   localparam int unsigned IDX_W = clog2(NUM_DIGITS);

   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    load;
   logic [BRIGHT_W-1:0]     brightness;
   logic [7:0]              seg_out;
   logic [NUM_DIGITS-1:0]   anode;
   logic [IDX_W-1:0]        digit_idx;
   logic                    frame_tick;

   modport master (
      output digits_in, dp_in, blank_in, load, brightness,
      input  seg_out, anode, digit_idx, frame_tick
   );

   modport slave (
      input  digits_in, dp_in, blank_in, load, brightness,
      output seg_out, anode, digit_idx, frame_tick
   );
endinterface

// File: rtl/sevenseg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment pattern (bit 0 = a).
//   nibble : hex value 0..F
//   seg_c  : g..a pattern, 1 = segment lit
module hex_to_seg
   import sevenseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);
   always_comb seg_c = SEG_TABLE[nibble];
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller with double-buffered
// display data, PWM brightness, anti-ghosting guard band and frame strobe.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of sevenseg_scan_ctrl_if (data in, pins out)
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS       = 4,
   parameter int unsigned SLOT_CYCLES      = 100000,
   parameter int unsigned BRIGHT_W         = 4,
   parameter int unsigned GUARD            = 2,
   parameter bit          ANODE_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   sevenseg_scan_ctrl_if.slave  bus
);
   localparam int unsigned SC_W  = clog2(SLOT_CYCLES);
   localparam int unsigned IDX_W = clog2(NUM_DIGITS);
   localparam int unsigned CMP_W = SC_W + 1;
   localparam int unsigned DW    = 4 * NUM_DIGITS;
   localparam int unsigned STEP  = SLOT_CYCLES >> BRIGHT_W;
   // XOR masks that turn active-high intent into pin polarity
   localparam logic [7:0]            SEG_POL = {8{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

   logic [SC_W-1:0]       slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
   logic                  frame_tick_q, frame_tick_d;
   logic [DW-1:0]         pend_digits_q, pend_digits_d, act_digits_q, act_digits_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic [7:0]            seg_out_q, seg_out_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;

   logic                  slot_end_c, frame_end_c, lit_c, show_c;
   logic [CMP_W-1:0]      thresh_c;
   logic [3:0]            cur_nib_c;
   logic                  cur_dp_c, cur_blank_c;
   logic [NUM_DIGITS-1:0] onehot_c;
   logic [6:0]            pat_c;

   hex_to_seg u_dec (
      .nibble (cur_nib_c),
      .seg_c  (pat_c)
   );

   // Pick the active-buffer fields for the currently scanned digit.
   always_comb begin
      cur_nib_c   = '0;
      cur_dp_c    = 1'b0;
      cur_blank_c = 1'b1;
      onehot_c    = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (digit_idx_q == IDX_W'(k)) begin
            cur_nib_c   = act_digits_q[k*4 +: 4];
            cur_dp_c    = act_dp_q[k];
            cur_blank_c = act_blank_q[k];
            onehot_c[k] = 1'b1;
         end
      end
   end

   // PWM window: after the guard band, up to brightness*STEP (full scale = whole slot).
   always_comb begin
      thresh_c = CMP_W'(bus.brightness) * CMP_W'(STEP);
      lit_c    = (slot_cnt_q >= SC_W'(GUARD)) &&
                 ((bus.brightness == '1) || ({1'b0, slot_cnt_q} < thresh_c));
      show_c   = lit_c && !cur_blank_c;
   end

   // Next-state: scan counters, buffer transfer at frame boundary, output regs.
   always_comb begin
      slot_cnt_d    = slot_cnt_q;
      digit_idx_d   = digit_idx_q;
      frame_tick_d  = 1'b0;
      pend_digits_d = pend_digits_q;
      pend_dp_d     = pend_dp_q;
      pend_blank_d  = pend_blank_q;
      act_digits_d  = act_digits_q;
      act_dp_d      = act_dp_q;
      act_blank_d   = act_blank_q;

      slot_end_c  = (slot_cnt_q == SC_W'(SLOT_CYCLES - 1));
      frame_end_c = slot_end_c && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

      slot_cnt_d = slot_end_c ? '0 : slot_cnt_q + SC_W'(1);
      if (slot_end_c) begin
         digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                : digit_idx_q + IDX_W'(1);
      end
      frame_tick_d = frame_end_c;

      if (bus.load) begin
         pend_digits_d = bus.digits_in;
         pend_dp_d     = bus.dp_in;
         pend_blank_d  = bus.blank_in;
      end
      // A load on the boundary cycle goes straight to the active buffer.
      if (frame_end_c) begin
         act_digits_d = bus.load ? bus.digits_in : pend_digits_q;
         act_dp_d     = bus.load ? bus.dp_in     : pend_dp_q;
         act_blank_d  = bus.load ? bus.blank_in  : pend_blank_q;
      end

      anode_d   = (show_c ? onehot_c : '0) ^ AN_POL;
      seg_out_d = (show_c ? {cur_dp_c, pat_c} : 8'h00) ^ SEG_POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt_q    <= '0;
         digit_idx_q   <= '0;
         frame_tick_q  <= 1'b0;
         pend_digits_q <= '0;
         pend_dp_q     <= '0;
         pend_blank_q  <= '1;
         act_digits_q  <= '0;
         act_dp_q      <= '0;
         act_blank_q   <= '1;
         seg_out_q     <= SEG_POL;
         anode_q       <= AN_POL;
      end else begin
         slot_cnt_q    <= slot_cnt_d;
         digit_idx_q   <= digit_idx_d;
         frame_tick_q  <= frame_tick_d;
         pend_digits_q <= pend_digits_d;
         pend_dp_q     <= pend_dp_d;
         pend_blank_q  <= pend_blank_d;
         act_digits_q  <= act_digits_d;
         act_dp_q      <= act_dp_d;
         act_blank_q   <= act_blank_d;
         seg_out_q     <= seg_out_d;
         anode_q       <= anode_d;
      end
   end

   assign bus.seg_out    = seg_out_q;
   assign bus.anode      = anode_q;
   assign bus.digit_idx  = digit_idx_q;
   assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Testbench for sevenseg_scan_ctrl: 4 digits, 16-cycle slots, 2-bit brightness,
// guard 2, active-low pins. A time-based display model is compared every cycle,
// plus hand-computed literal checks at chosen scan positions.
module tb_sevenseg_scan_ctrl;
   localparam int ND = 4;
   localparam int SC = 16;
   localparam int BW = 2;
   localparam int G  = 2;
   localparam int STEP = SC >> BW;
   localparam int FRAME = ND * SC;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

   sevenseg_scan_ctrl #(
      .NUM_DIGITS(ND), .SLOT_CYCLES(SC), .BRIGHT_W(BW), .GUARD(G),
      .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;  default: return 7'b1110001;
      endcase
   endfunction

   // Model: m_t = clock edges since reset release; edge m_t scans position m_t.
   int          m_t;
   logic [15:0] m_pd, m_ad;
   logic [3:0]  m_pdp, m_adp, m_pbl, m_abl;
   logic [7:0]  e_seg;
   logic [3:0]  e_an;
   logic [1:0]  e_idx;
   logic        e_tick;
   int          s_m, d_m;
   logic        lit_m, on_m;

   always @(posedge clk) begin
      if (rst) begin
         m_t = 0;
         m_pd = 16'h0; m_ad = 16'h0; m_pdp = 4'h0; m_adp = 4'h0;
         m_pbl = 4'hF; m_abl = 4'hF;
         e_seg = 8'hFF; e_an = 4'hF; e_idx = 2'd0; e_tick = 1'b0;
      end else begin
         s_m = m_t % SC;
         d_m = (m_t / SC) % ND;
         lit_m = (s_m >= G) && ((bus.brightness == 2'd3) || (s_m < int'(bus.brightness) * STEP));
         on_m  = lit_m && !m_abl[d_m];
         e_an  = on_m ? ~(4'b0001 << d_m) : 4'hF;
         e_seg = on_m ? ~{m_adp[d_m], hex7(m_ad[d_m*4 +: 4])} : 8'hFF;
         e_tick = (s_m == SC - 1) && (d_m == ND - 1);
         if (bus.load) begin
            m_pd = bus.digits_in; m_pdp = bus.dp_in; m_pbl = bus.blank_in;
         end
         if (e_tick) begin
            m_ad = m_pd; m_adp = m_pdp; m_abl = m_pbl;
         end
         m_t = m_t + 1;
         e_idx = 2'((m_t / SC) % ND);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at pos %0d", nm, act, exp, m_t - 1);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_seg",  32'(bus.seg_out),    32'(e_seg));
         chk("model_an",   32'(bus.anode),      32'(e_an));
         chk("model_idx",  32'(bus.digit_idx),  32'(e_idx));
         chk("model_tick", 32'(bus.frame_tick), 32'(e_tick));
      end
   end

   // Advance to the negedge where outputs show scan position p.
   task automatic wait_abs(input int p);
      int n;
      n = 0;
      while ((m_t - 1) != p && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if ((m_t - 1) != p) begin
         checks++;
         errors++;
         $display("FAIL wait_pos: reached %0d required %0d", m_t - 1, p);
      end
   endtask

   task automatic pins(input string nm, input logic [3:0] an, input logic [7:0] seg);
      chk({nm, "_anode"}, 32'(bus.anode), 32'(an));
      chk({nm, "_seg"},   32'(bus.seg_out), 32'(seg));
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      bus.digits_in = d; bus.dp_in = dp; bus.blank_in = bl; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.load = 1'b0; bus.digits_in = 16'h0; bus.dp_in = 4'h0;
      bus.blank_in = 4'h0; bus.brightness = 2'd3;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      pins("reset", 4'hF, 8'hFF);
      chk("reset_idx",  32'(bus.digit_idx), 32'd0);
      chk("reset_tick", 32'(bus.frame_tick), 32'd0);
      rst = 1'b0;

      // Scan order with 3A71
      @(negedge clk);
      do_load(16'h3A71, 4'h0, 4'h0);
      wait_abs(FRAME - 1);
      chk("tick_f0", 32'(bus.frame_tick), 32'd1);
      chk("idx_f0",  32'(bus.digit_idx), 32'd0);
      wait_abs(65);  pins("guard", 4'hF, 8'hFF);
      wait_abs(66);  pins("d0", 4'hE, 8'hF9);
      wait_abs(85);  pins("d1", 4'hD, 8'hF8);
      wait_abs(111); pins("d2", 4'hB, 8'h88);
      wait_abs(114); pins("d3", 4'h7, 8'hB0);
      wait_abs(127); chk("tick_f1", 32'(bus.frame_tick), 32'd1);

      // Tear-free load while digit 2 is displayed
      wait_abs(165); do_load(16'hFFFF, 4'h0, 4'h0);
      wait_abs(168); pins("tear_d2", 4'hB, 8'h88);
      wait_abs(181); pins("tear_d3", 4'h7, 8'hB0);
      wait_abs(194); pins("newF_d0", 4'hE, 8'h8E);

      // Brightness 1 then 0
      wait_abs(200); bus.brightness = 2'd1;
      wait_abs(226); pins("br1_s2", 4'hB, 8'h8E);
      wait_abs(227); pins("br1_s3", 4'hB, 8'h8E);
      wait_abs(228); pins("br1_s4", 4'hF, 8'hFF);
      wait_abs(240); bus.brightness = 2'd0;
      wait_abs(258); pins("br0", 4'hF, 8'hFF);
      wait_abs(259); bus.brightness = 2'd3;

      // Blank digit 2, dp on digit 0
      wait_abs(260); do_load(16'h3A71, 4'b0001, 4'b0100);
      wait_abs(322); pins("dp_d0", 4'hE, 8'h79);
      wait_abs(338); pins("nodp_d1", 4'hD, 8'hF8);
      wait_abs(354); pins("blank_d2", 4'hF, 8'hFF);
      wait_abs(370); pins("nodp_d3", 4'h7, 8'hB0);

      // Reset mid-scan while digit 2 is selected
      wait_abs(419);
      chk("pre_rst_idx", 32'(bus.digit_idx), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      pins("midrst", 4'hF, 8'hFF);
      chk("midrst_idx",  32'(bus.digit_idx), 32'd0);
      chk("midrst_tick", 32'(bus.frame_tick), 32'd0);
      rst = 1'b0;
      wait_abs(30); pins("post_rst_dark", 4'hF, 8'hFF);

      // Load exactly on the frame-boundary cycle
      wait_abs(FRAME - 2); do_load(16'h0123, 4'h0, 4'h0);
      chk("bypass_tick", 32'(bus.frame_tick), 32'd1);
      wait_abs(66);  pins("bypass_d0", 4'hE, 8'hB0);
      wait_abs(114); pins("bypass_d3", 4'h7, 8'hC0);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Parametrised N-digit multiplexed seven-segment display controller. Successor to the fixed 4-digit clock-divider-plus-mux arrangement.
- Takes packed hex nibbles, decimal-point and blank masks. Drives a common segment bus plus one anode per digit.
- Scanning is by an internal refresh counter on the single system clock; no divided clocks.
- Adds tear-free double-buffered loading, PWM brightness, ghost-suppression guard band and a frame strobe.
- Sits between data sources (LFSR, counters) and board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..16).
- SLOT_CYCLES, 100000, clk cycles each digit is selected; must be >= 2**BRIGHT_W and > GUARD.
- BRIGHT_W, 4, brightness control width.
- GUARD, 2, cycles at the start of each slot with all anodes off (anti-ghosting).
- ANODE_ACTIVE_LOW, 1, 1 = anode asserted low.
- SEG_ACTIVE_LOW, 1, 1 = segment lit low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- digits_in  in  4*NUM_DIGITS  nibble k = digit k (digit 0 rightmost)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  NUM_DIGITS  1 = digit dark
- load  in  1  capture digits_in/dp_in/blank_in into pending buffer
- brightness  in  BRIGHT_W  0 = off, all-ones = full
- seg_out  out  8  [0]=a .. [6]=g, [7]=dp, polarity per SEG_ACTIVE_LOW
- anode  out  NUM_DIGITS  one-hot select, polarity per ANODE_ACTIVE_LOW
- digit_idx  out  clog2(NUM_DIGITS) (min 1)  digit currently selected
- frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (synchronous, wins over everything):
  - slot_cnt=0, digit_idx=0, frame_tick=0.
  - Pending and active buffers: digits 0, dp 0, blank all ones.
  - seg_out all segments unlit; anode all deasserted. Active-low defaults: seg_out=8'hFF, anode all ones.
- slot_cnt counts 0..SLOT_CYCLES-1. At terminal count it returns to 0 and digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary = cycle where slot_cnt is terminal and digit_idx==NUM_DIGITS-1. frame_tick is registered and high the following cycle, coincident with digit_idx==0.
- Buffering:
  - load=1 captures the inputs into pending on that edge.
  - At each frame boundary, active <= pending. If load is high on the boundary cycle, active <= inputs directly (bypass) and pending also updates.
  - Active never changes mid-frame.
- STEP = SLOT_CYCLES >> BRIGHT_W (localparam).
- lit_window:
  - true when slot_cnt >= GUARD and (brightness == all-ones, or slot_cnt < brightness*STEP).
  - brightness=0 -> never lit.
  - Brightness is sampled live, not buffered.
- Outputs registered, one-cycle latency from slot_cnt/digit_idx:
  - anode[digit_idx] asserted iff lit_window and !active_blank[digit_idx]; all others deasserted.
  - seg_out = decode(active nibble[digit_idx]) plus dp bit from active_dp, polarity applied. When the anode is off, seg_out is forced unlit.
- Decode, active-high g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- NUM_DIGITS=1: digit_idx stays 0; frame_tick pulses once per slot.
- Widths: slot_cnt is clog2(SLOT_CYCLES) bits. The brightness*STEP compare is done at clog2(SLOT_CYCLES)+1 bits, so there is no overflow.

Decomposition:
- Package sevenseg_pkg holds:
  - the 16-entry segment pattern constants
  - SEG_DP bit index
  - the clog2 helper function
- Sub-module hex_to_seg (combinational): 4-bit nibble -> 7-bit active-high pattern.
- Polarity inversion is applied only in sevenseg_scan_ctrl's output register.

Test Plan:
- Bench parameters for all scenarios: NUM_DIGITS=4, SLOT_CYCLES=16, BRIGHT_W=2, GUARD=2, active-low.
- Reset check: rst held 3 cycles -> seg_out=8'hFF, anode=4'hF, digit_idx=0, frame_tick=0. Nothing lights until the first frame boundary after a load.
- Scan order: load digits_in=16'h3A71, blank=0, brightness=3.
  - After the next frame boundary, anode goes 1110, 1101, 1011, 0111, each 14 cycles (cycles 2..15 of the slot, after 1-cycle latency).
  - seg_out=~{0,0000110}, then ~{0,0000111}, then ~{0,1110111}, then ~{0,1001111}.
  - frame_tick pulses every 64 cycles.
- Tear-free load: pulse load with 16'hFFFF while digit 2 is displayed -> digits 2 and 3 keep old values through frame end. All digits show F (seg_out=8'h8E) from the next frame.
- Brightness: brightness=1 (STEP=4) -> anode asserted only at slot_cnt 2..3 (2 cycles per slot). brightness=0 -> anode stays 4'hF.
- Blank/dp: blank_in=4'b0100, dp_in=4'b0001 -> digit 2's anode is never asserted. Digit 0 has seg_out[7]=0 (lit); the other digits have seg_out[7]=1.
- Reset mid-scan plus boundary bypass:
  - Assert rst while digit_idx=2 -> all state returns to reset values on the next edge.
  - Load on the exact frame-boundary cycle -> the new data appears in frame 1, not frame 2.
